// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline control logic.
package riscv_pipe_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   // A pipeline bubble is an all-zero register image.
   localparam logic [31:0] BUBBLE = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } pipe_state_e;

   function automatic logic load_use_hazard(
      input logic                  memread,
      input logic [REG_ADDR_W-1:0] rd,
      input logic [REG_ADDR_W-1:0] rs1,
      input logic [REG_ADDR_W-1:0] rs2
   );
      return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones, clears on reset.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-timeout fault trap.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
`ifdef PIPE_CTRL_PERF_EN
   ,
   parameter int unsigned PERF_W      = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_memread,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  mem_wb_flush,
   output logic                  stall,
   output logic                  mem_fault
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0]     perf_stall_cnt,
   output logic [PERF_W-1:0]     perf_flush_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   pipe_state_e      state;
   logic [CNT_W-1:0] wait_cnt;
   logic             fault;
   logic             mem_stall;
   logic             hazard;

   assign hazard = load_use_hazard(ex_memread, ex_rd, id_rs1, id_rs2);

   // Once waiting, the access is outstanding until mem_ready regardless of mem_req.
   assign mem_stall = (state == MEM_WAIT) ? ~mem_ready :
                      (state == RUN)      ? (mem_req & ~mem_ready) : 1'b0;

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (reset) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (state != FAULT) begin
         if (mem_stall) begin
            mem_wb_flush = 1'b1;
         end else if (ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
         end else if (hazard) begin
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            id_ex_flush  = 1'b1;
         end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
         end
      end
   end

   assign stall     = ~pc_write;
   assign mem_fault = fault;

   // The counter includes the first stall cycle seen in RUN, so the fault fires
   // after exactly MEM_TIMEOUT consecutive wait cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == CNT_LAST) begin
                  state    <= FAULT;
                  wait_cnt <= '0;
                  fault    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            FAULT: begin
               state <= FAULT;
               fault <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   sat_counter #(
      .WIDTH(PERF_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .en   (stall && (state != FAULT)),
      .count(perf_stall_cnt)
   );

   sat_counter #(
      .WIDTH(PERF_W)
   ) u_flush_cnt (
      .clk  (clk),
      .reset(reset),
      .en   (if_id_flush && !reset),
      .count(perf_flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases then random traffic
// against a cycle-level model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned T = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       ex_memread = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;
   logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic       if_id_flush, id_ex_flush, mem_wb_flush, stall, mem_fault;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT(T)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .PERF_W(32)
`endif
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .ex_rd          (ex_rd),
      .ex_memread     (ex_memread),
      .ex_branch_taken(ex_branch_taken),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .id_ex_write    (id_ex_write),
      .ex_mem_write   (ex_mem_write),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .mem_wb_flush   (mem_wb_flush),
      .stall          (stall),
      .mem_fault      (mem_fault)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   typedef struct {
      logic [8:0]  vec;
      logic [31:0] ps;
      logic [31:0] pf;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Model state: length of the current wait run and the sticky fault.
   int          m_wait = 0;
   bit          m_fault = 0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   // Vector order: pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, stall, fault
   task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic req, input logic rdy, input string tag);
      exp_t e;
      bit   mstall;
      bit   lu;
      @(posedge clk);
      #1;
      reset = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
      ex_memread = mr; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
      e.tag = tag;
      if (r) begin
         m_wait = 0; m_fault = 0; m_stall = '0; m_flush = '0;
         e.vec = 9'b0000_111_1_0;
         e.ps = '0; e.pf = '0;
      end else begin
         e.ps = m_stall; e.pf = m_flush;
         if (m_fault) begin
            e.vec = 9'b0000_000_1_1;
         end else begin
            mstall = (m_wait > 0) ? !rdy : (req && !rdy);
            lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
            if (mstall) begin
               e.vec = 9'b0000_001_1_0;
               m_wait++;
               if (m_wait == T) begin
                  m_fault = 1; m_wait = 0;
               end
               if (m_stall != '1) m_stall++;
            end else begin
               m_wait = 0;
               if (br) begin
                  e.vec = 9'b1111_110_0_0;
                  if (m_flush != '1) m_flush++;
               end else if (lu) begin
                  e.vec = 9'b0011_010_1_0;
                  if (m_stall != '1) m_stall++;
               end else begin
                  e.vec = 9'b1111_000_0_0;
               end
            end
         end
      end
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t       e;
      logic [8:0] got;
      if (q.size() > 0) begin
         e = q.pop_front();
         got = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, mem_wb_flush, stall, mem_fault};
         n_checks++;
         if (got !== e.vec) begin
            n_fail++;
            $display("FAIL %s t=%0t outputs got=%b expected=%b", e.tag, $time, got, e.vec);
         end
`ifdef PIPE_CTRL_PERF_EN
         n_checks++;
         if (perf_stall_cnt !== e.ps) begin
            n_fail++;
            $display("FAIL %s t=%0t perf_stall_cnt got=%0d expected=%0d", e.tag, $time,
                     perf_stall_cnt, e.ps);
         end
         n_checks++;
         if (perf_flush_cnt !== e.pf) begin
            n_fail++;
            $display("FAIL %s t=%0t perf_flush_cnt got=%0d expected=%0d", e.tag, $time,
                     perf_flush_cnt, e.pf);
         end
`endif
      end
   end

   initial begin
      int hold_off;
      hold_off = 0;
      step(1, 0, 0, 0, 0, 0, 0, 1, "reset0");
      step(1, 0, 0, 0, 0, 0, 0, 1, "reset1");
      step(0, 0, 0, 0, 0, 0, 0, 1, "idle");
      step(0, 1, 5, 5, 1, 0, 0, 1, "loaduse");
      step(0, 1, 5, 0, 0, 0, 0, 1, "loaduse_bubble");
      step(0, 0, 0, 0, 1, 0, 0, 1, "x0_nohazard");
      step(0, 3, 3, 3, 1, 1, 0, 1, "branch_over_lu");
      step(0, 0, 0, 0, 0, 0, 0, 1, "idle2");
      step(1, 0, 0, 0, 0, 0, 0, 1, "reset_perf");
      repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0, "memwait");
      step(0, 0, 0, 0, 0, 0, 1, 1, "memwait_ready_last");
      step(0, 0, 0, 0, 0, 0, 0, 1, "after_wait");
      repeat (T) step(0, 0, 0, 0, 0, 0, 1, 0, "timeout_wait");
      step(0, 2, 2, 2, 1, 1, 0, 1, "fault_hold0");
      step(0, 0, 0, 0, 0, 0, 1, 0, "fault_hold1");
      step(0, 0, 0, 0, 0, 0, 0, 1, "fault_hold2");
      step(1, 0, 0, 0, 0, 0, 0, 1, "reset_in_fault");
      step(0, 0, 0, 0, 0, 0, 0, 1, "post_fault_run");
      for (int i = 0; i < 500; i++) begin
         logic rdy;
         if (hold_off == 0 && ($urandom % 25) == 0) hold_off = $urandom_range(2, 6);
         if (hold_off > 0) begin
            rdy = 1'b0;
            hold_off--;
         end else begin
            rdy = ($urandom % 4) != 0;
         end
         step(($urandom % 70) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom % 2), ($urandom % 6) == 0,
              ($urandom % 3) == 0 || hold_off > 0, rdy, "random");
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain queue_left=%0d expected=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Every cycle, decides whether each pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) captures, holds or loads a bubble, based on load-use hazards, taken branches and data-memory wait states.
- A small FSM tracks multi-cycle memory waits and traps a memory timeout into a sticky fault that freezes the pipeline until reset.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max consecutive wait cycles on one data-memory access before fault; legal range ≥ 2.
- PERF_W, 32: width of the performance counters (present only with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in IF/ID.
- ex_rd  in  5  destination register of the instruction in ID/EX.
- ex_memread  in  1  instruction in ID/EX is a load.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle.
- mem_req  in  1  MEM stage holds a load/store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  capture enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all zeros) at the next edge; flush overrides write.
- stall  out  1  high when pc_write = 0.
- mem_fault  out  1  sticky timeout fault.
- perf_stall_cnt, perf_flush_cnt  out  PERF_W each  present only with PIPE_CTRL_PERF_EN.

## Operation
- The FSM has three states: RUN, MEM_WAIT, FAULT.
- Outputs are Mealy: combinational from the current state and inputs. The state, wait counter and fault flag are registered.
- Condition priority in RUN, and in the MEM_WAIT cycle where mem_ready = 1:
  1. Memory stall (mem_req & ~mem_ready): all writes 0, mem_wb_flush = 1, other flushes 0. Next state is MEM_WAIT.
  2. Branch taken: all writes 1, if_id_flush = 1, id_ex_flush = 1.
  3. Load-use (ex_memread & ex_rd ≠ 0 & (ex_rd = id_rs1 | ex_rd = id_rs2)): pc_write = 0, if_id_write = 0, id_ex_flush = 1, ex_mem_write = 1.
  4. Otherwise: all writes 1, all flushes 0.
- Register x0 never causes a hazard.
- MEM_WAIT:
  - While mem_ready = 0: outputs as in memory stall; the wait counter increments.
  - On the cycle mem_ready = 1: outputs per the RUN priority list (minus condition 1). Next state RUN, counter cleared.
  - If the counter reaches MEM_TIMEOUT−1 with mem_ready = 0: next state FAULT, mem_fault set.
- FAULT:
  - All writes 0, all flushes 0, stall = 1, mem_fault = 1.
  - Held until reset; all inputs ignored.
- Wait counter width is $clog2(MEM_TIMEOUT). It never wraps: it clears on leaving MEM_WAIT.

## Timing
- Reset values (asynchronous, held while reset = 1):
  - state RUN, counter 0, mem_fault 0, perf counters 0.
  - All write outputs 0, all flush outputs 1, stall 1.
- First deassertion edge: normal RUN evaluation.
- Decision latency: zero cycles. Enables/flushes take effect at the same posedge that samples them.
- A load-use stall lasts exactly 1 cycle. The dependent instruction re-evaluates against the bubble the next cycle.
- A mem_ready arriving on the timeout cycle wins: no fault.
- Branch and load-use in the same cycle: branch wins; no extra stall.
- Reset during MEM_WAIT or FAULT returns to RUN at once.

## Configuration
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt counts cycles with stall = 1 outside FAULT.
  - perf_flush_cnt counts cycles with if_id_flush = 1 outside reset.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package riscv_pipe_pkg holds:
  - the state enum (RUN, MEM_WAIT, FAULT);
  - REG_ADDR_W = 5;
  - the bubble constant (32'h0000_0013 not used; bubble = zero).
- One natural sub-module: sat_counter (PERF_W wide, enable, saturating), instantiated twice under the macro.

## Test plan
- Reset, then idle inputs: cycle after reset, all writes 1, flushes 0, stall 0, mem_fault 0.
- ex_memread = 1, ex_rd = 5, id_rs2 = 5: pc_write = 0, if_id_write = 0, id_ex_flush = 1 for exactly one cycle. Repeat with ex_rd = 0: no stall.
- ex_branch_taken = 1 together with the load-use condition: if_id_flush = 1, id_ex_flush = 1, pc_write = 1, no stall.
- mem_req = 1, mem_ready low 3 cycles then high: 3 stall cycles with mem_wb_flush = 1, then RUN; with perf enabled, perf_stall_cnt = 3.
- MEM_TIMEOUT = 4, mem_ready never asserted: FAULT entered after 4 wait cycles, mem_fault = 1 held. Assert reset mid-FAULT: mem_fault drops immediately.
- mem_ready asserted on cycle MEM_TIMEOUT−1: returns to RUN, mem_fault stays 0.
